// File: rtl/frmgen_param.sv
// frmgen_param: tag-to-reader reply frame generator.
// Serialises preamble (FM0 or Miller, optional extended pilot), payload
// fetched over a data_req handshake, optional CRC (CRC_W bits, MSB first)
// and an end-of-signaling dummy '1', one bit per clk_frm cycle.
// Build option: define FRMGEN_NO_DUMMY_EN to drop the dummy bit so DONE
// follows the last data/CRC bit directly.
module frmgen_param #(
  parameter int LEN_W         = 8,
  parameter int CRC_W         = 16,
  parameter int PILOT_FM0_EXT = 12,
  parameter int PILOT_MIL_EXT = 16
) (
  input  logic             clk_frm,
  input  logic             rst_for_new_package,
  input  logic             start,
  input  logic [1:0]       m,
  input  logic             trext,
  input  logic [LEN_W-1:0] len,
  input  logic             en_crc,
  input  logic             reply_data,
  input  logic [CRC_W-1:0] crc_in,
  output logic             send_data,
  output logic             bit_vld,
  output logic             data_req,
  output logic             en_fm0,
  output logic             st_enc,
  output logic             pre_p_complete,
  output logic             p_complete,
  output logic             fg_complete
);

  localparam int CNT_W = LEN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DATA, S_CRC, S_EOS, S_DONE
  } state_t;

`ifdef FRMGEN_NO_DUMMY_EN
  localparam state_t TAIL = S_DONE;
`else
  localparam state_t TAIL = S_EOS;
`endif

  // The state names the bit loaded into send_data at the next edge, so each
  // bit is visible one cycle after its state is active.
  state_t           state, state_d;
  logic [1:0]       m_q, m_d;
  logic             trext_q, trext_d;
  logic             crc_en_q, crc_en_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [LEN_W-1:0] pay_cnt, pay_d;
  logic             send_d, vld_d, st_d, pre_d, pc_d, fg_d;
  logic             fm0_q;
  logic [CRC_W-1:0] crc_sh;
  state_t           after_pay, after_pre;

  function automatic logic [CNT_W-1:0] pilot_len(input logic fm0, input logic ext);
    if (fm0) return ext ? CNT_W'(PILOT_FM0_EXT) : '0;
    else     return ext ? CNT_W'(PILOT_MIL_EXT) : CNT_W'(4);
  endfunction

  function automatic logic [CNT_W-1:0] pre_len(input logic fm0, input logic ext);
    return pilot_len(fm0, ext) + CNT_W'(6);
  endfunction

  // Sync patterns stored LSB = first transmitted bit.
  function automatic logic pre_bit(input logic [CNT_W-1:0] idx,
                                   input logic fm0, input logic ext);
    logic [CNT_W-1:0] p;
    logic [5:0]       pat;
    logic [5:0]       sh;
    p = pilot_len(fm0, ext);
    if (idx < p) return 1'b0;
    pat = fm0 ? 6'b100101 : 6'b111010;
    sh  = pat >> (idx - p);
    return sh[0];
  endfunction

  assign en_fm0 = (m == 2'b00);
  assign fm0_q  = (m_q == 2'b00);
  assign crc_sh = crc_in >> cnt;

  // Next-state, next-bit and handshake decode.
  always_comb begin
    state_d  = state;
    m_d      = m_q;
    trext_d  = trext_q;
    crc_en_d = crc_en_q;
    len_d    = len_q;
    cnt_d    = cnt;
    pay_d    = pay_cnt;
    send_d   = send_data;
    vld_d    = bit_vld;
    st_d     = st_enc;
    pre_d    = pre_p_complete;
    pc_d     = p_complete;
    fg_d     = fg_complete;
    data_req = 1'b0;

    after_pay = crc_en_q ? S_CRC : TAIL;
    after_pre = (len_q != '0) ? S_DATA : after_pay;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          m_d      = m;
          trext_d  = trext;
          crc_en_d = en_crc;
          len_d    = len;
          cnt_d    = CNT_W'(1);
          pay_d    = '0;
          send_d   = pre_bit('0, m == 2'b00, trext);
          vld_d    = 1'b1;
          st_d     = 1'b1;
          pre_d    = 1'b0;
          pc_d     = 1'b0;
          fg_d     = 1'b0;
          state_d  = S_PRE;
        end else if (state == S_DONE) begin
          send_d = 1'b1;
          vld_d  = 1'b0;
          st_d   = 1'b0;
          pre_d  = 1'b0;
          pc_d   = 1'b0;
          fg_d   = 1'b1;
        end
      end
      S_PRE: begin
        send_d = pre_bit(cnt, fm0_q, trext_q);
        vld_d  = 1'b1;
        pre_d  = (cnt == pre_len(fm0_q, trext_q) - CNT_W'(1));
        if (pre_d) begin
          state_d = after_pre;
          cnt_d   = CNT_W'(CRC_W - 1);
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        data_req = 1'b1;
        send_d   = reply_data;
        vld_d    = 1'b1;
        pre_d    = 1'b0;
        pc_d     = 1'b1;
        pay_d    = pay_cnt + LEN_W'(1);
        if (pay_cnt == len_q - LEN_W'(1)) state_d = after_pay;
      end
      S_CRC: begin
        send_d = crc_sh[0];
        vld_d  = 1'b1;
        pre_d  = 1'b0;
        pc_d   = 1'b1;
        if (cnt == '0) state_d = TAIL;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      S_EOS: begin
        send_d  = 1'b1;
        vld_d   = 1'b1;
        pre_d   = 1'b0;
        pc_d    = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched frame setup, counters and registered outputs.
  always_ff @(posedge clk_frm or posedge rst_for_new_package) begin
    if (rst_for_new_package) begin
      state          <= S_IDLE;
      m_q            <= '0;
      trext_q        <= 1'b0;
      crc_en_q       <= 1'b0;
      len_q          <= '0;
      cnt            <= '0;
      pay_cnt        <= '0;
      send_data      <= 1'b0;
      bit_vld        <= 1'b0;
      st_enc         <= 1'b0;
      pre_p_complete <= 1'b0;
      p_complete     <= 1'b0;
      fg_complete    <= 1'b0;
    end else begin
      state          <= state_d;
      m_q            <= m_d;
      trext_q        <= trext_d;
      crc_en_q       <= crc_en_d;
      len_q          <= len_d;
      cnt            <= cnt_d;
      pay_cnt        <= pay_d;
      send_data      <= send_d;
      bit_vld        <= vld_d;
      st_enc         <= st_d;
      pre_p_complete <= pre_d;
      p_complete     <= pc_d;
      fg_complete    <= fg_d;
    end
  end

endmodule

// File: tb/tb_frmgen_param.sv
// Scoreboard bench for frmgen_param: one instance with CRC_W=16, one with
// CRC_W=5. Each frame's expected bit stream is built from the framing rules
// and queued; a monitor pops one entry per bit_vld cycle.
module tb_frmgen_param;

  typedef struct packed {
    logic b;
    logic pl;
    logic pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [1:0]  m = 2'b00;
  logic        trext = 1'b0;
  logic        en_crc = 1'b0;
  logic        reply_data = 1'b0;
  logic [7:0]  len = '0;
  logic [15:0] crc = '0;
  logic        st16, st5;

  logic sd16, vld16, req16, fm16, se16, pp16, pc16, fg16;
  logic sd5, vld5, req5, fm5, se5, pp5, pc5, fg5;
  logic c_sd, c_vld, c_req, c_fm, c_se, c_pp, c_pc, c_fg;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q16[$];
  exp_t q5[$];
  logic payload[$];

  always #5 clk = ~clk;

  assign st16 = start & ~sel;
  assign st5  = start & sel;

  frmgen_param #(.LEN_W(8), .CRC_W(16), .PILOT_FM0_EXT(12), .PILOT_MIL_EXT(16)) dut16 (
    .clk_frm(clk), .rst_for_new_package(rst), .start(st16), .m(m), .trext(trext),
    .len(len), .en_crc(en_crc), .reply_data(reply_data), .crc_in(crc),
    .send_data(sd16), .bit_vld(vld16), .data_req(req16), .en_fm0(fm16),
    .st_enc(se16), .pre_p_complete(pp16), .p_complete(pc16), .fg_complete(fg16)
  );

  frmgen_param #(.LEN_W(8), .CRC_W(5), .PILOT_FM0_EXT(12), .PILOT_MIL_EXT(16)) dut5 (
    .clk_frm(clk), .rst_for_new_package(rst), .start(st5), .m(m), .trext(trext),
    .len(len), .en_crc(en_crc), .reply_data(reply_data), .crc_in(crc[4:0]),
    .send_data(sd5), .bit_vld(vld5), .data_req(req5), .en_fm0(fm5),
    .st_enc(se5), .pre_p_complete(pp5), .p_complete(pc5), .fg_complete(fg5)
  );

  always_comb begin
    if (sel) begin
      c_sd = sd5; c_vld = vld5; c_req = req5; c_fm = fm5;
      c_se = se5; c_pp = pp5;  c_pc = pc5;   c_fg = fg5;
    end else begin
      c_sd = sd16; c_vld = vld16; c_req = req16; c_fm = fm16;
      c_se = se16; c_pp = pp16;  c_pc = pc16;   c_fg = fg16;
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic mon(input bit k, input logic sd, input logic vld, input logic pp,
                     input logic pc, input logic se, input logic fg);
    exp_t e;
    int   sz;
    if (vld) begin
      sz = k ? q5.size() : q16.size();
      if (sz == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_bit dut%0d: bit_vld=1 with no bit expected (t=%0t)",
                 k ? 5 : 16, $time);
      end else begin
        e = k ? q5.pop_front() : q16.pop_front();
        chk(k ? "send_data5" : "send_data16", 32'(sd), 32'(e.b));
        chk("pre_p_complete", 32'(pp), 32'(e.pl));
        chk("p_complete", 32'(pc), 32'(e.pc));
        chk("st_enc_high", 32'(se), 32'd1);
        chk("fg_low_in_frame", 32'(fg), 32'd0);
      end
    end
  endtask

  // Monitor: compares every presented bit against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      mon(1'b0, sd16, vld16, pp16, pc16, se16, fg16);
      mon(1'b1, sd5, vld5, pp5, pc5, se5, fg5);
    end
  end

  // mid: 0 none, -1 random cycle, >0 cycle of a spurious start.
  // abort: 0 none, else cycle at which reset is pulsed.
  task automatic frame(input bit which, input logic [1:0] mm, input logic tx,
                       input logic [7:0] ln, input logic ec, input logic [15:0] cv,
                       input int mid, input int abort);
    exp_t fr[$];
    logic pre[$];
    logic [5:0]  s;
    logic [5:0]  t6;
    logic [15:0] t16;
    int lnn, pilot, n, pi, fgc, req_n, first_req, crcw, mc;
    lnn = int'(ln);
    while (payload.size() < lnn) payload.push_back(1'($urandom_range(1)));

    if (mm == 2'b00) begin
      pilot = tx ? 12 : 0;
      s = 6'b101001;
    end else begin
      pilot = tx ? 16 : 4;
      s = 6'b010111;
    end
    for (int i = 0; i < pilot; i++) pre.push_back(1'b0);
    for (int i = 5; i >= 0; i--) begin
      t6 = s >> i;
      pre.push_back(t6[0]);
    end
    for (int i = 0; i < pre.size(); i++)
      fr.push_back('{b: pre[i], pl: (i == pre.size() - 1), pc: 1'b0});
    for (int i = 0; i < lnn; i++) fr.push_back('{b: payload[i], pl: 1'b0, pc: 1'b1});
    crcw = which ? 5 : 16;
    if (ec) begin
      for (int i = crcw - 1; i >= 0; i--) begin
        t16 = cv >> i;
        fr.push_back('{b: t16[0], pl: 1'b0, pc: 1'b1});
      end
    end
`ifndef FRMGEN_NO_DUMMY_EN
    fr.push_back('{b: 1'b1, pl: 1'b0, pc: 1'b1});
`endif
    n = fr.size();
    mc = (mid < 0) ? 2 + int'($urandom_range(n - 3)) : mid;
    foreach (fr[i]) begin
      if (which) q5.push_back(fr[i]);
      else       q16.push_back(fr[i]);
    end

    @(negedge clk);
    sel = which; m = mm; trext = tx; len = ln; en_crc = ec; crc = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fgc = 0; req_n = 0; first_req = 0; pi = 0;
    for (int cyc = 1; cyc <= n + 10; cyc++) begin
      if (cyc == 1) begin
        chk("first_bit_latency", 32'(c_vld), 32'd1);
        chk("st_enc_rise", 32'(c_se), 32'd1);
        chk("fg_cleared_on_start", 32'(c_fg), 32'd0);
        chk("en_fm0", 32'(c_fm), 32'(mm == 2'b00));
      end
      if (abort != 0 && cyc == abort) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_send_data", 32'(c_sd), 32'd0);
        chk("rst_bit_vld", 32'(c_vld), 32'd0);
        chk("rst_st_enc", 32'(c_se), 32'd0);
        chk("rst_pre_p", 32'(c_pp), 32'd0);
        chk("rst_p_complete", 32'(c_pc), 32'd0);
        chk("rst_fg", 32'(c_fg), 32'd0);
        q16.delete();
        q5.delete();
        payload.delete();
        #2 rst = 1'b0;
        return;
      end
      if (c_fg) begin
        fgc = cyc;
        break;
      end
      if (c_req) begin
        req_n++;
        if (first_req == 0) first_req = cyc;
        reply_data = (pi < lnn) ? payload[pi] : 1'($urandom_range(1));
        pi++;
      end
      if (mid != 0 && cyc == mc) begin
        start = 1'b1; m = ~mm; trext = ~tx; len = ln + 8'd3; en_crc = ~ec;
      end else begin
        start = 1'b0; m = mm; trext = tx; len = ln; en_crc = ec;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("fg_cycle", 32'(fgc), 32'(n + 1));
    chk("done_send_data", 32'(c_sd), 32'd1);
    chk("done_bit_vld", 32'(c_vld), 32'd0);
    chk("done_p_complete", 32'(c_pc), 32'd0);
    chk("done_st_enc", 32'(c_se), 32'd0);
    chk("done_data_req", 32'(c_req), 32'd0);
    chk("data_req_count", 32'(req_n), 32'(lnn));
    if (lnn != 0) chk("first_req_cycle", 32'(first_req), 32'(pre.size()));
    chk("queue_drained", 32'(which ? q5.size() : q16.size()), 32'd0);
    @(negedge clk);
    chk("done_hold_fg", 32'(c_fg), 32'd1);
    chk("done_hold_idle", 32'(c_sd), 32'd1);
    payload.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_send_data", 32'(sd16), 32'd0);
    chk("reset_bit_vld", 32'(vld16), 32'd0);
    chk("reset_st_enc", 32'(se16), 32'd0);
    chk("reset_pre_p", 32'(pp16), 32'd0);
    chk("reset_p_complete", 32'(pc16), 32'd0);
    chk("reset_fg", 32'(fg16), 32'd0);
    chk("reset_fg5", 32'(fg5), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // FM0, short payload 1,0,1,1, no CRC
    payload.push_back(1'b1); payload.push_back(1'b0);
    payload.push_back(1'b1); payload.push_back(1'b1);
    frame(1'b0, 2'b00, 1'b0, 8'd4, 1'b0, 16'h0000, 0, 0);
    // Miller M=4 extended pilot, empty payload, CRC-16
    frame(1'b0, 2'b10, 1'b1, 8'd0, 1'b1, 16'hA5C3, 0, 0);
    // CRC-5 instance, FM0 extended pilot
    frame(1'b1, 2'b00, 1'b1, 8'd2, 1'b1, 16'h0016, 0, 0);
    // spurious start during DATA, then back-to-back start from DONE
    frame(1'b0, 2'b01, 1'b0, 8'd6, 1'b1, 16'($urandom), 12, 0);
    frame(1'b0, 2'b00, 1'b1, 8'd5, 1'b0, 16'h0000, 0, 0);
    // reset during CRC, then a clean frame
    frame(1'b0, 2'b00, 1'b0, 8'd3, 1'b1, 16'($urandom), 0, 14);
    @(negedge clk);
    frame(1'b0, 2'b11, 1'b0, 8'd5, 1'b1, 16'($urandom), 0, 0);

    for (int r = 0; r < 14; r++) begin
      frame(1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
            8'($urandom_range(24)), 1'($urandom_range(1)), 16'($urandom),
            ($urandom_range(1) == 1) ? -1 : 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
